tally_block_reader: RTL and testbench
=====================================

Name: tally_block_reader

Overview:
Consumer end of the vote accumulator's chunked read interface. On a start pulse it walks all NUM_BLOCKS words of the stored tally, pacing the accumulator with single-cycle request_next pulses. It honours the accumulator's 2-cycle re-valid latency, captures each word, and serialises it as bytes (LSB byte first, block 0 first) to a byte-wide ready/valid sink, such as the UART transmitter.

Parameters:
REGISTER_SIZE, 32, word width of accumulator blocks; must be a multiple of 8
NUM_BITS_STORED, 4096, total tally width; NUM_BLOCKS = NUM_BITS_STORED/REGISTER_SIZE

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
start_in  input  1  pulse; begin dumping the full tally (ignored unless IDLE)
block_in  input  REGISTER_SIZE  accumulator data word
block_valid_in  input  1  accumulator word valid
request_next_out  output  1  single-cycle pulse; accumulator advances to next block
byte_out  output  8  serialised byte
byte_valid_out  output  1  byte_out valid
byte_ready_in  input  1  sink accepts byte when valid&&ready
busy_out  output  1  high in any state other than IDLE
done_out  output  1  single-cycle pulse after last byte accepted
block_count_out  output  $clog2(NUM_BLOCKS)+1  blocks fully emitted in current dump

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE, all outputs 0, counters 0, shift register 0.
- States: IDLE, WAIT_VALID, GUARD1, GUARD2, CAPTURE, SEND, ADVANCE, FINISH.
- IDLE: on start_in go to WAIT_VALID, block_count_out<=0. The accumulator's current block is block 0; no request is issued first.
- WAIT_VALID: stay until block_valid_in=1, then go to CAPTURE.
- CAPTURE: latch block_in into the shift register, byte_idx<=0, go to SEND. This takes exactly one cycle.
- SEND:
  - byte_out = shift_reg[7:0] and byte_valid_out=1.
  - On handshake, shift right by 8 and byte_idx++.
  - On handshake of the byte where byte_idx==REGISTER_SIZE/8-1, do block_count_out++. Then go to FINISH if block_count_out+1==NUM_BLOCKS, else ADVANCE.
  - byte_out and byte_valid_out must hold stable while byte_ready_in=0.
- ADVANCE: request_next_out=1 for exactly this cycle, then GUARD1.
- GUARD1, GUARD2: block_valid_in is ignored. In the request cycle the accumulator still shows stale valid, and valid returns no earlier than 2 cycles later. After GUARD2 go to WAIT_VALID.
- FINISH: done_out=1 for one cycle, then IDLE. No request is issued after the last block, so the accumulator pointer is left on its final block.
- Minimum latency:
  - start_in to first byte_valid_out: 2 cycles (WAIT_VALID with valid already high, then CAPTURE).
  - Block-to-block with byte_ready_in tied high: REGISTER_SIZE/8 + 5 cycles.
- Boundaries:
  - start_in while busy: ignored.
  - block_valid_in dropping mid-SEND: no effect, because data is already captured.
  - byte_ready_in held low indefinitely: stall in SEND with no timeout.
  - NUM_BLOCKS==1: FINISH directly after the first block; request_next_out never asserts.
  - Reset mid-dump: immediate return to IDLE with outputs cleared. A partially emitted block is not resumed.
- request_next_out and done_out are never high in the same cycle.

Optional Feature:
Macro TALLY_READER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of every accepted byte is maintained, cleared on start_in.
  - After the last data byte the FSM enters an extra state CHKSUM that presents the XOR on byte_out with byte_valid_out=1, under the same ready/valid rules.
  - done_out pulses after the checksum byte is accepted.
  - Total bytes per dump = NUM_BITS_STORED/8 + 1.
- Not defined: no XOR logic, no CHKSUM state, exactly NUM_BITS_STORED/8 bytes per dump.

Test Plan:
- REGISTER_SIZE=32, NUM_BITS_STORED=128; model accumulator (valid drops 1 cycle after request, returns 2 cycles later) holding words 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; start_in, ready high -> bytes 0x01..0x10 in order, exactly 3 request pulses, done_out once, block_count_out=4.
- Same setup, byte_ready_in toggled every other cycle -> identical 16-byte sequence, byte_out stable whenever valid&&!ready.
- Model holds stale valid with old data in the request cycle and 1 cycle after -> no word re-captured; byte 0x05 follows 0x04.
- rst_in low asynchronously during block 2 SEND -> outputs 0 immediately; new start_in dumps all 16 bytes from block 0 (model also reset).
- NUM_BITS_STORED=32, word 0xDEADBEEF -> bytes EF, BE, AD, DE; request_next_out never asserted; done_out pulse.
- With TALLY_READER_CHECKSUM_EN, first scenario -> 17 bytes, last = XOR(0x01..0x10) = 0x10; done_out after the 17th byte.

Source files
------------

// File: rtl/tally_block_reader_if.sv
// Signal bundle between the tally reader, the accumulator's chunked read port and a byte sink.
// The master modport is the reader; the slave modport is its environment.
interface tally_block_reader_if #(
    parameter int REGISTER_SIZE   = 32,
    parameter int NUM_BITS_STORED = 4096
);
    localparam int NUM_BLOCKS = NUM_BITS_STORED / REGISTER_SIZE;
    localparam int CNT_W      = $clog2(NUM_BLOCKS) + 1;

    logic                     start_in;
    logic [REGISTER_SIZE-1:0] block_in;
    logic                     block_valid_in;
    logic                     request_next_out;
    logic [7:0]               byte_out;
    logic                     byte_valid_out;
    logic                     byte_ready_in;
    logic                     busy_out;
    logic                     done_out;
    logic [CNT_W-1:0]         block_count_out;

    modport master (
        input  start_in, block_in, block_valid_in, byte_ready_in,
        output request_next_out, byte_out, byte_valid_out, busy_out, done_out, block_count_out
    );

    modport slave (
        output start_in, block_in, block_valid_in, byte_ready_in,
        input  request_next_out, byte_out, byte_valid_out, busy_out, done_out, block_count_out
    );
endinterface

// File: rtl/tally_block_reader.sv
// Walks every accumulator block and streams it LSB byte first, block 0 first, to a byte sink.
// Define TALLY_READER_CHECKSUM_EN to append an XOR checksum byte after the last data byte.
module tally_block_reader #(
    parameter int REGISTER_SIZE   = 32,
    parameter int NUM_BITS_STORED = 4096
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    tally_block_reader_if.master bus
);
    localparam int NUM_BLOCKS      = NUM_BITS_STORED / REGISTER_SIZE;
    localparam int BYTES_PER_BLOCK = REGISTER_SIZE / 8;
    localparam int IDX_W           = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
    localparam int CNT_W           = $clog2(NUM_BLOCKS) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BYTES_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0] LAST_BLOCK = CNT_W'(NUM_BLOCKS - 1);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_VALID,
        GUARD1,
        GUARD2,
        CAPTURE,
        SEND,
        ADVANCE,
        FINISH
`ifdef TALLY_READER_CHECKSUM_EN
        , CHKSUM
`endif
    } state_t;

`ifdef TALLY_READER_CHECKSUM_EN
    localparam state_t AFTER_LAST = CHKSUM;
`else
    localparam state_t AFTER_LAST = FINISH;
`endif

    state_t                   r_state;
    state_t                   w_next_state;
    logic [REGISTER_SIZE-1:0] r_shift;
    logic [IDX_W-1:0]         r_byte_idx;
    logic [CNT_W-1:0]         r_block_count;
    logic                     w_byte_valid;
    logic                     w_request;
    logic                     w_done;
    logic                     w_fire;
    logic                     w_last_byte;
    logic [7:0]               w_byte;

    assign w_fire      = w_byte_valid && bus.byte_ready_in;
    assign w_last_byte = (r_byte_idx == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_byte_valid = 1'b0;
        w_request    = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            IDLE:       if (bus.start_in) w_next_state = WAIT_VALID;
            WAIT_VALID: if (bus.block_valid_in) w_next_state = CAPTURE;
            CAPTURE:    w_next_state = SEND;
            SEND: begin
                w_byte_valid = 1'b1;
                if (bus.byte_ready_in && w_last_byte) begin
                    w_next_state = (r_block_count == LAST_BLOCK) ? AFTER_LAST : ADVANCE;
                end
            end
            ADVANCE: begin
                w_request    = 1'b1;
                w_next_state = GUARD1;
            end
            // The accumulator still shows the old word as valid here; valid is not trusted until after GUARD2.
            GUARD1:     w_next_state = GUARD2;
            GUARD2:     w_next_state = WAIT_VALID;
            FINISH: begin
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
`ifdef TALLY_READER_CHECKSUM_EN
            CHKSUM: begin
                w_byte_valid = 1'b1;
                if (bus.byte_ready_in) w_next_state = FINISH;
            end
`endif
            default:    w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_shift       <= '0;
            r_byte_idx    <= '0;
            r_block_count <= '0;
        end else begin
            if (r_state == IDLE && bus.start_in) begin
                r_block_count <= '0;
            end
            if (r_state == CAPTURE) begin
                r_shift    <= bus.block_in;
                r_byte_idx <= '0;
            end
            if (r_state == SEND && w_fire) begin
                r_shift    <= r_shift >> 8;
                r_byte_idx <= r_byte_idx + IDX_W'(1);
                if (w_last_byte) r_block_count <= r_block_count + CNT_W'(1);
            end
        end
    end

`ifdef TALLY_READER_CHECKSUM_EN
    logic [7:0] r_xor;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_xor <= '0;
        end else if (r_state == IDLE && bus.start_in) begin
            r_xor <= '0;
        end else if (r_state == SEND && w_fire) begin
            r_xor <= r_xor ^ r_shift[7:0];
        end
    end

    assign w_byte = (r_state == CHKSUM) ? r_xor : r_shift[7:0];
`else
    assign w_byte = r_shift[7:0];
`endif

    assign bus.byte_out         = w_byte;
    assign bus.byte_valid_out   = w_byte_valid;
    assign bus.request_next_out = w_request;
    assign bus.done_out         = w_done;
    assign bus.busy_out         = (r_state != IDLE);
    assign bus.block_count_out  = r_block_count;
endmodule

// File: tb/tb_tally_block_reader.sv
// Bench for tally_block_reader: a 4-block reader driven by an accumulator model and a 1-block reader.
// Expected byte streams are rebuilt from the stored words; honours TALLY_READER_CHECKSUM_EN.
module tb_tally_block_reader;
    localparam int RS    = 32;
    localparam int NBITS = 128;
    localparam int NBLK  = NBITS / RS;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    tally_block_reader_if #(.REGISTER_SIZE(RS), .NUM_BITS_STORED(NBITS)) if_a ();
    tally_block_reader_if #(.REGISTER_SIZE(RS), .NUM_BITS_STORED(RS))    if_b ();

    tally_block_reader #(.REGISTER_SIZE(RS), .NUM_BITS_STORED(NBITS)) dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .bus(if_a.master)
    );
    tally_block_reader #(.REGISTER_SIZE(RS), .NUM_BITS_STORED(RS)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .bus(if_b.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- accumulator model ----------------
    logic [31:0] words [NBLK];
    int ptr = 0, phase = 0, extra = 0;
    bit stale = 0, hide = 0, acc_reset = 0;

    always @(posedge clk_in) begin
        #1;
        if (acc_reset || !rst_in) begin
            ptr = 0; phase = 0;
            if_a.block_in = words[0]; if_a.block_valid_in = 1'b1;
        end else if (phase == 0) begin
            if (if_a.request_next_out) phase = 1;
            else if (hide) begin if_a.block_valid_in = 1'b0; if_a.block_in = $urandom; end
            else begin if_a.block_valid_in = 1'b1; if_a.block_in = words[ptr]; end
        end else begin
            phase++;
            if ((phase == 2 && !stale) || phase == 3) begin
                if_a.block_valid_in = 1'b0; if_a.block_in = $urandom;
            end
            if (phase >= 4 + extra) begin
                ptr++; phase = 0;
                if_a.block_in = words[ptr]; if_a.block_valid_in = 1'b1;
            end
        end
    end

    // ---------------- sink ready driver ----------------
    int ready_mode = 0;
    logic rdy = 1'b1;
    always @(posedge clk_in) begin
        #1;
        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = ~rdy;
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b0;
        endcase
        if_a.byte_ready_in = rdy;
        if_b.byte_ready_in = rdy;
    end

    // ---------------- monitors ----------------
    logic [7:0] q_a[$], q_b[$];
    int t_a[$];
    int cyc = 0, req_a = 0, done_a = 0, both_a = 0, stab_a = 0, stall_a = 0, at_done_a = 0;
    int req_b = 0, done_b = 0, at_done_b = 0;
    bit prev_stall_a = 0;
    logic [7:0] prev_byte_a = '0;

    always @(negedge clk_in) begin
        cyc++;
        if (rst_in) begin
            if (if_a.byte_valid_out && if_a.byte_ready_in) begin
                q_a.push_back(if_a.byte_out); t_a.push_back(cyc);
            end
            if (if_a.byte_valid_out && !if_a.byte_ready_in) stall_a++;
            if (if_a.request_next_out) req_a++;
            if (if_a.done_out) begin done_a++; at_done_a = q_a.size(); end
            if (if_a.request_next_out && if_a.done_out) both_a++;
            if (prev_stall_a && (!if_a.byte_valid_out || if_a.byte_out != prev_byte_a)) stab_a++;
            prev_stall_a = if_a.byte_valid_out && !if_a.byte_ready_in;
            prev_byte_a  = if_a.byte_out;
            if (if_b.byte_valid_out && if_b.byte_ready_in) q_b.push_back(if_b.byte_out);
            if (if_b.request_next_out) req_b++;
            if (if_b.done_out) begin done_b++; at_done_b = q_b.size(); end
        end else begin
            prev_stall_a = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    logic [7:0] exp_a[$], exp_b[$];

    task automatic build_exp_a();
        logic [7:0] x;
        x = '0;
        exp_a.delete();
        for (int k = 0; k < NBLK; k++)
            for (int b = 0; b < RS / 8; b++) begin
                exp_a.push_back(words[k][8*b +: 8]);
                x = x ^ words[k][8*b +: 8];
            end
`ifdef TALLY_READER_CHECKSUM_EN
        exp_a.push_back(x);
`endif
    endtask

    task automatic clear_mon();
        q_a.delete(); t_a.delete(); q_b.delete();
        req_a = 0; done_a = 0; both_a = 0; stab_a = 0; stall_a = 0; at_done_a = 0;
        req_b = 0; done_b = 0; at_done_b = 0;
    endtask

    task automatic reset_model();
        @(negedge clk_in); acc_reset = 1'b1;
        @(negedge clk_in); acc_reset = 1'b0;
    endtask

    task automatic pulse_start_a();
        @(negedge clk_in); if_a.start_in = 1'b1;
        @(negedge clk_in); if_a.start_in = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        int i;
        i = 0;
        while (done_a == 0 && i < 3000) begin @(negedge clk_in); i++; end
        n_checks++;
        if (done_a == 0) begin
            n_fail++; $display("FAIL %s: timeout waiting for done_out, got 0 pulses, want 1", name);
        end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic compare_dump_a(input string name);
        int bad;
        bad = -1;
        n_checks++;
        if (q_a.size() !== exp_a.size()) begin
            n_fail++; $display("FAIL %s byte count: got %0d want %0d", name, q_a.size(), exp_a.size());
        end
        for (int i = 0; i < q_a.size() && i < exp_a.size(); i++)
            if (bad < 0 && q_a[i] !== exp_a[i]) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL %s byte[%0d]: got %h want %h", name, bad, q_a[bad], exp_a[bad]);
        end
        n_checks++;
        if (req_a !== NBLK - 1) begin
            n_fail++; $display("FAIL %s request pulses: got %0d want %0d", name, req_a, NBLK - 1);
        end
        n_checks++;
        if (done_a !== 1 || at_done_a !== exp_a.size()) begin
            n_fail++; $display("FAIL %s done: got %0d pulses after %0d bytes, want 1 after %0d", name, done_a, at_done_a, exp_a.size());
        end
        n_checks++;
        if (both_a !== 0 || stab_a !== 0) begin
            n_fail++; $display("FAIL %s overlap/stability: got %0d/%0d want 0/0", name, both_a, stab_a);
        end
        n_checks++;
        if (if_a.block_count_out !== 3'(NBLK) || if_a.busy_out !== 1'b0) begin
            n_fail++; $display("FAIL %s count/busy: got %0d/%b want %0d/0", name, if_a.block_count_out, if_a.busy_out, NBLK);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk_in);
        n_checks++;
        if ({if_a.busy_out, if_a.byte_valid_out, if_a.request_next_out, if_a.done_out, if_a.block_count_out, if_a.byte_out} !== '0) begin
            n_fail++; $display("FAIL reset_a: got busy=%b valid=%b req=%b done=%b cnt=%0d byte=%h want all 0",
                if_a.busy_out, if_a.byte_valid_out, if_a.request_next_out, if_a.done_out, if_a.block_count_out, if_a.byte_out);
        end
        n_checks++;
        if ({if_b.busy_out, if_b.byte_valid_out, if_b.request_next_out, if_b.done_out, if_b.block_count_out, if_b.byte_out} !== '0) begin
            n_fail++; $display("FAIL reset_b: got busy=%b valid=%b cnt=%0d byte=%h want all 0",
                if_b.busy_out, if_b.byte_valid_out, if_b.block_count_out, if_b.byte_out);
        end
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_basic();
        words = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        stale = 0; extra = 0; ready_mode = 0;
        build_exp_a(); reset_model(); clear_mon();
        pulse_start_a();
        // now at the negedge of the WAIT_VALID cycle
        n_checks++;
        if (if_a.byte_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL latency: byte_valid one cycle after start got %b want 0", if_a.byte_valid_out);
        end
        @(negedge clk_in);
        n_checks++;
        if (if_a.byte_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL latency: byte_valid in capture cycle got %b want 0", if_a.byte_valid_out);
        end
        @(negedge clk_in);
        n_checks++;
        if (if_a.byte_valid_out !== 1'b1 || if_a.byte_out !== 8'h01) begin
            n_fail++; $display("FAIL latency: two cycles after start got valid=%b byte=%h want 1/01", if_a.byte_valid_out, if_a.byte_out);
        end
        repeat (3) @(negedge clk_in);
        pulse_start_a();
        wait_done_a("basic");
        compare_dump_a("basic");
        n_checks++;
        if (t_a.size() < 9 || t_a[4] - t_a[0] !== 9 || t_a[8] - t_a[4] !== 9) begin
            n_fail++; $display("FAIL block_to_block: got %0d cycles want 9", (t_a.size() >= 5) ? t_a[4] - t_a[0] : -1);
        end
    endtask

    task automatic test_ready_toggle();
        ready_mode = 1;
        build_exp_a(); reset_model(); clear_mon();
        pulse_start_a();
        wait_done_a("toggle");
        compare_dump_a("toggle");
        n_checks++;
        if (stall_a == 0) begin
            n_fail++; $display("FAIL toggle stalls: got %0d stalled cycles want >0", stall_a);
        end
        ready_mode = 0;
    endtask

    task automatic test_stale_valid();
        stale = 1; ready_mode = 0;
        build_exp_a(); reset_model(); clear_mon();
        pulse_start_a();
        wait_done_a("stale");
        compare_dump_a("stale");
        n_checks++;
        if (q_a.size() < 5 || q_a[3] !== 8'h04 || q_a[4] !== 8'h05) begin
            n_fail++; $display("FAIL stale order: got %h,%h want 04,05", (q_a.size() > 3) ? q_a[3] : 8'hxx, (q_a.size() > 4) ? q_a[4] : 8'hxx);
        end
        stale = 0;
    endtask

    task automatic test_stall_and_valid_drop();
        int i;
        ready_mode = 3;
        build_exp_a(); reset_model(); clear_mon();
        pulse_start_a();
        i = 0;
        while (!if_a.byte_valid_out && i < 50) begin @(negedge clk_in); i++; end
        hide = 1;
        repeat (30) @(negedge clk_in);
        n_checks++;
        if (if_a.byte_valid_out !== 1'b1 || if_a.byte_out !== 8'h01 || if_a.busy_out !== 1'b1) begin
            n_fail++; $display("FAIL stall hold: got valid=%b byte=%h busy=%b want 1/01/1", if_a.byte_valid_out, if_a.byte_out, if_a.busy_out);
        end
        n_checks++;
        if (q_a.size() !== 0 || stab_a !== 0) begin
            n_fail++; $display("FAIL stall accept: got %0d bytes, %0d unstable cycles, want 0/0", q_a.size(), stab_a);
        end
        hide = 0; ready_mode = 0;
        wait_done_a("stall");
        compare_dump_a("stall");
    endtask

    task automatic test_reset_mid_dump();
        int i;
        foreach (words[k]) words[k] = $urandom;
        ready_mode = 0;
        build_exp_a(); reset_model(); clear_mon();
        pulse_start_a();
        i = 0;
        while (q_a.size() < 9 && i < 500) begin @(negedge clk_in); #2; i++; end
        rst_in = 1'b0;
        #1;
        n_checks++;
        if ({if_a.busy_out, if_a.byte_valid_out, if_a.request_next_out, if_a.done_out, if_a.block_count_out, if_a.byte_out} !== '0
            || q_a.size() < 9) begin
            n_fail++; $display("FAIL async reset: got busy=%b valid=%b cnt=%0d byte=%h after %0d bytes, want all 0 after 9",
                if_a.busy_out, if_a.byte_valid_out, if_a.block_count_out, if_a.byte_out, q_a.size());
        end
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        reset_model(); clear_mon();
        pulse_start_a();
        wait_done_a("after_reset");
        compare_dump_a("after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            foreach (words[k]) words[k] = $urandom;
            stale = 1'($urandom_range(0, 1));
            extra = $urandom_range(0, 3);
            ready_mode = 2;
            build_exp_a(); reset_model(); clear_mon();
            pulse_start_a();
            wait_done_a($sformatf("random%0d", r));
            compare_dump_a($sformatf("random%0d", r));
        end
        stale = 0; extra = 0; ready_mode = 0;
    endtask

    task automatic test_single_block();
        int i;
        logic [31:0] w;
        w = 32'hDEADBEEF;
        exp_b.delete();
        for (int b = 0; b < 4; b++) exp_b.push_back(w[8*b +: 8]);
`ifdef TALLY_READER_CHECKSUM_EN
        exp_b.push_back(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
`endif
        ready_mode = 0; clear_mon();
        @(negedge clk_in); if_b.start_in = 1'b1;
        @(negedge clk_in); if_b.start_in = 1'b0;
        i = 0;
        while (done_b == 0 && i < 200) begin @(negedge clk_in); i++; end
        repeat (2) @(negedge clk_in);
        n_checks++;
        if (q_b.size() !== exp_b.size() || q_b != exp_b) begin
            n_fail++; $display("FAIL single bytes: got %0d bytes first=%h want %0d bytes first=%h",
                q_b.size(), (q_b.size() > 0) ? q_b[0] : 8'hxx, exp_b.size(), exp_b[0]);
        end
        n_checks++;
        if (req_b !== 0) begin
            n_fail++; $display("FAIL single request: got %0d pulses want 0", req_b);
        end
        n_checks++;
        if (done_b !== 1 || at_done_b !== exp_b.size()) begin
            n_fail++; $display("FAIL single done: got %0d pulses after %0d bytes want 1 after %0d", done_b, at_done_b, exp_b.size());
        end
        n_checks++;
        if (if_b.block_count_out !== 1'b1 || if_b.busy_out !== 1'b0) begin
            n_fail++; $display("FAIL single count/busy: got %0d/%b want 1/0", if_b.block_count_out, if_b.busy_out);
        end
    endtask

    initial begin
        words = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        if_a.start_in = 1'b0; if_b.start_in = 1'b0;
        if_a.byte_ready_in = 1'b1; if_b.byte_ready_in = 1'b1;
        if_a.block_in = '0; if_a.block_valid_in = 1'b0;
        if_b.block_in = 32'hDEADBEEF; if_b.block_valid_in = 1'b1;
        test_reset();
        test_basic();
        test_ready_toggle();
        test_stale_valid();
        test_stall_and_valid_drop();
        test_reset_mid_dump();
        test_random();
        test_single_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
